// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the word-indexed PC, drives instruction memory and
// fills the IF/ID register, with stall, branch redirect/flush and halt-on-zero-word.
module fetch_unit #(
    parameter logic [31:0] PC_RESET   = 32'd0,
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    output logic        imem_re,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted
);

    localparam logic [31:0] ADDR_MASK = 32'(IMEM_DEPTH - 1);

    generate
        if (IMEM_DEPTH < 2 || (IMEM_DEPTH & (IMEM_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("fetch_unit: IMEM_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    // Addresses are kept full width but always masked, so the upper bits stay zero.
    function automatic logic [31:0] wrap_addr(input logic [31:0] a);
        return a & ADDR_MASK;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] a);
        return wrap_addr(a + 32'd1);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;

        if (branch_taken) begin
            // Redirect flushes the wrong-path word and also revives a speculative halt.
            state_d = S_RUN;
            pc_d    = wrap_addr(branch_target);
            instr_d = NOP_INSTR;
            ipc_d   = 32'd0;
            valid_d = 1'b0;
        end else if (state_q == S_RUN && !stall) begin
            if (imem_data == 32'd0) begin
                state_d = S_HALT;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                pc_d    = next_pc(pc_q);
                instr_d = imem_data;
                ipc_d   = pc_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= wrap_addr(PC_RESET);
            instr_q <= NOP_INSTR;
            ipc_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign imem_re     = (state_q == S_RUN);
    assign halted      = (state_q == S_HALT);
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign if_id_valid = valid_q;

endmodule
